// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with valid/ready handshakes (optional ovf via SERIAL_ADDER_OVF_EN)

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    // Sum is the XOR of the inputs; carry is their AND
    always_comb begin
        s = x ^ y;
        c = x & y;
    end
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last_bit;
    logic             s1, c1, fa_s, c2, fa_co;

    // Full-adder cell built from two half adders and an OR
    half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(s1),   .c(c1));
    half_adder u_ha1 (.x(s1),      .y(carry),   .s(fa_s), .c(c2));
    assign fa_co = c1 | c2;

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; in_ready is masked while reset is held
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_nxt = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-bit shifting and final result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            c_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= c_in;
                cnt   <= '0;
            end else if (state == ADD) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                carry  <= fa_co;
                // Hold the counter on the final bit so it never wraps
                if (last_bit) begin
                    sum   <= {fa_s, sum_sh[WIDTH-1:1]};
                    c_out <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry still holds the carry into the MSB here
                    ovf   <= carry ^ fa_co;
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic       c_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       c_out;
    logic       busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .busy(busy)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set; the edge inside is edge k
    task automatic start(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a = av; b = bv; c_in = cv; in_valid = 1'b1;
        check("in_ready_before_accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("in_ready_drop", in_ready, 1'b0);
        check("busy_add", busy, 1'b1);
    endtask

    // Wait edges k+1..k+8 and check the result appears exactly after k+8
    task automatic wait_result(input string tag, input logic [7:0] es, input logic ec);
        logic early;
        early = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            if (out_valid) early = 1'b1;
        end
        check({tag, "_no_early_valid"}, early, 1'b0);
        tick();
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_c_out"}, c_out, ec);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consume_out_valid", out_valid, 1'b0);
        check("consume_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] held_sum;
        logic       held_c, seen;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_c_out", c_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        start(8'h0F, 8'h01, 1'b0);
        wait_result("op_0f_01", 8'h10, 1'b0);
        consume();

        start(8'hFF, 8'h01, 1'b0);
        wait_result("op_ff_01", 8'h00, 1'b1);
        consume();

        start(8'hFF, 8'hFF, 1'b1);
        wait_result("op_ff_ff_c1", 8'hFF, 1'b1);
        held_sum = sum; held_c = c_out;
        // Backpressure window with an ignored operand pulse
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin a = 8'h55; b = 8'h55; in_valid = 1'b1; end
            tick();
            in_valid = 1'b0;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_sum", sum, held_sum);
            check("bp_c_out", c_out, held_c);
            check("bp_in_ready", in_ready, 1'b0);
        end
        consume();
        tick();
        check("ignored_no_busy", busy, 1'b0);

        // Reset during ADD discards the operation
        start(8'h12, 8'h34, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sum", sum, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("midrst_never_presented", seen, 1'b0);

        // Back-to-back with out_ready tied high: accepts at k and k+10
        out_ready = 1'b1;
        a = 8'h0F; b = 8'h01; c_in = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'h12; b = 8'h34;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (i == 10) in_valid = 1'b0;
            check("b2b_out_valid", out_valid, (i == 8 || i == 18));
            if (i == 8)  check("b2b_sum0", sum, 8'h10);
            if (i == 18) check("b2b_sum1", sum, 8'h46);
        end
        out_ready = 1'b0;

`ifdef SERIAL_ADDER_OVF_EN
        start(8'h7F, 8'h01, 1'b0);
        wait_result("ovf_7f_01", 8'h80, 1'b0);
        check("ovf_7f_01_ovf", ovf, 1'b1);
        consume();
        start(8'hFF, 8'h01, 1'b0);
        wait_result("ovf_ff_01", 8'h00, 1'b1);
        check("ovf_ff_01_ovf", ovf, 1'b0);
        consume();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
